uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one byte-serial UART transmitter among NUM_REQ independent requesters (console, debug monitor, log engine, etc.).
- Arbitrates round-robin, sequences the transmitter's start/ready handshake, and locks the grant for multi-byte messages until the message's last byte.
- Releases a lock if the owner stalls mid-message past a bounded hold time.
- Sits between the requesters and the UART transmitter's data_in/start_write/ready ports.

Parameters:
- NUM_REQ, 4, number of requesters; must be ≥2.
- HOLD_TIMEOUT, 1024, clk cycles a locked requester may idle between bytes before its lock is revoked; must be ≥1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  requester i has a byte on its data lane
- req_data  in  8*NUM_REQ  byte lanes; lane i = bits [8i+7:8i]
- req_last  in  NUM_REQ  lane i byte ends its message
- req_ready  out  NUM_REQ  transfer accepted on lane i this cycle; one-hot or zero
- uart_data  out  8  byte to transmitter
- uart_start  out  1  one-cycle start pulse to transmitter
- uart_ready  in  1  transmitter idle
- grant_id  out  $clog2(NUM_REQ)  current or last owner
- busy  out  1  state != S_IDLE
- hold_expired  out  1  one-cycle pulse when a lock is revoked by timeout

Behaviour:
- Reset: state=S_IDLE, req_ready=0, uart_start=0, uart_data=0, grant_id=NUM_REQ-1, busy=0, hold_expired=0, hold counter=0. Reset asserted mid-message aborts immediately; uart_start drops asynchronously.
- States: S_IDLE, S_SEND, S_WAIT_BUSY, S_WAIT_DONE, S_HOLD.
- Lane-i transfer: req_valid[i] & req_ready[i] in the same cycle. req_ready is combinational from state, uart_ready and req_valid.
- S_IDLE:
  - If uart_ready=1 and any req_valid is set, pick winner g by round-robin starting at (grant_id+1) mod NUM_REQ, wrapping.
  - Assert req_ready[g]; capture req_data lane g and req_last[g]; set grant_id=g; go to S_SEND.
  - If uart_ready=0, accept nothing.
- S_SEND: uart_start=1 for exactly this cycle; uart_data holds the captured byte, stable from S_SEND until the next capture. Go to S_WAIT_BUSY.
- S_WAIT_BUSY: stay until uart_ready=0, then go to S_WAIT_DONE. The transmitter drops ready the cycle after start; no timeout applies here.
- S_WAIT_DONE: stay until uart_ready=1.
  - If the captured last=1, go to S_IDLE; grant_id stays as the round-robin pointer.
  - Otherwise clear the hold counter and go to S_HOLD.
- S_HOLD:
  - req_ready[grant_id]=req_valid[grant_id]; all other lanes get 0.
  - On transfer: capture byte and last, go to S_SEND.
  - Else increment the counter. When the counter reaches HOLD_TIMEOUT-1 with no transfer, pulse hold_expired and go to S_IDLE.
  - A transfer in the expiring cycle takes precedence: no pulse.
- Latency: valid in S_IDLE with uart_ready=1 at cycle t gives uart_start at t+1. Within a message, the byte is accepted the first S_HOLD cycle it is valid, and uart_start follows one cycle later.
- Fairness: one message per grant; a requester cannot win twice in a row while another is valid at release.
- req_data and req_last are sampled only on transfer; other lanes may change freely.
- Counter width: $clog2(HOLD_TIMEOUT+1); no wrap is possible.

Decomposition:
- Shared package/header holds:
  - state encodings (3-bit localparams)
  - IDX_W=$clog2(NUM_REQ) helper
- Sub-module rr_pick (combinational): inputs req vector and pointer; outputs winner index and any_req. Reusable for other shared-resource arbiters.

Test Plan:
- Transmitter model drops ready 1 cycle after start and raises it 20 cycles later.
- Single byte: lane 2 valid, data=0x41, last=1 → req_ready[2] for 1 cycle; uart_start one cycle later with uart_data=0x41; grant_id=2; busy returns 0 after ready rises.
- Round-robin: all 4 lanes valid with last=1 from reset → grant order 0,1,2,3,0; exactly one uart_start per byte; never two starts without an intervening ready low/high.
- Lock: lane 1 sends 0x10,0x11,0x12 (last on 0x12) while lane 3 stays valid → lane 3 not granted until after 0x12 completes; next grant is 3.
- Hold timeout, HOLD_TIMEOUT=8: lane 0 sends 0x55 last=0 then goes idle; lane 1 valid → hold_expired pulses after 8 S_HOLD cycles; lane 1 granted next.
- Async reset in S_WAIT_DONE → all outputs at reset values with no clock edge; after release, lane 0 valid is granted first.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: state encoding and sizing helper shared by the UART transmit arbiter files
package uart_tx_arbiter_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SEND      = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_HOLD      = 3'd4
    } state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search starting one position past the previous owner
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] winner,
    output logic          any_req
);

    logic [IW-1:0] idx;

    // scan from the farthest position back to the nearest so the closest requester after ptr wins
    always_comb begin
        winner = '0;
        idx    = '0;
        for (int k = N; k >= 1; k--) begin
            idx = IW'((int'(ptr) + k) % N);
            if (req[idx]) winner = idx;
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one byte-serial UART transmitter among NUM_REQ requesters with message locking
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int HOLD_TIMEOUT = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [8*NUM_REQ-1:0]      req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [7:0]                uart_data,
    output logic                      uart_start,
    input  logic                      uart_ready,
    output logic [idx_w(NUM_REQ)-1:0] grant_id,
    output logic                      busy,
    output logic                      hold_expired
);

    localparam int IDX_W = idx_w(NUM_REQ);
    localparam int CNT_W = $clog2(HOLD_TIMEOUT + 1);

    state_t           state;
    logic             last_q;
    logic [CNT_W-1:0] hold_cnt;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] sel;
    logic             any_req;
    logic             take;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IDX_W)
    ) u_pick (
        .req     (req_valid),
        .ptr     (grant_id),
        .winner  (winner),
        .any_req (any_req)
    );

    // a byte is taken either from the fresh round-robin winner or from the locked owner mid-message
    always_comb begin
        sel       = (state == S_HOLD) ? grant_id : winner;
        take      = (state == S_IDLE) ? (uart_ready & any_req) :
                    (state == S_HOLD) ? req_valid[grant_id] : 1'b0;
        req_ready = take ? (NUM_REQ'(1) << sel) : '0;
    end

    assign busy = (state != S_IDLE);

    // transmitter handshake sequencing, byte capture and lock timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            uart_start   <= 1'b0;
            uart_data    <= '0;
            last_q       <= 1'b0;
            grant_id     <= IDX_W'(NUM_REQ - 1);
            hold_cnt     <= '0;
            hold_expired <= 1'b0;
        end else begin
            uart_start   <= 1'b0;
            hold_expired <= 1'b0;
            if (take) begin
                uart_data  <= req_data[{sel, 3'b000} +: 8];
                last_q     <= req_last[sel];
                grant_id   <= sel;
                uart_start <= 1'b1;
                state      <= S_SEND;
            end else begin
                case (state)
                    S_IDLE:      state <= S_IDLE;
                    S_SEND:      state <= S_WAIT_BUSY;
                    S_WAIT_BUSY: if (!uart_ready) state <= S_WAIT_DONE;
                    S_WAIT_DONE: if (uart_ready) begin
                        state    <= last_q ? S_IDLE : S_HOLD;
                        hold_cnt <= '0;
                    end
                    S_HOLD: if (hold_cnt == CNT_W'(HOLD_TIMEOUT - 1)) begin
                        hold_expired <= 1'b1;
                        state        <= S_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                    default:     state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench with a transmitter model and a message-level arbitration model
module tb_uart_tx_arbiter;

    localparam int NUM = 4;
    localparam int HT  = 8;

    logic             clk;
    logic             rst_n;
    logic [NUM-1:0]   req_valid;
    logic [8*NUM-1:0] req_data;
    logic [NUM-1:0]   req_last;
    logic [NUM-1:0]   req_ready;
    logic [7:0]       uart_data;
    logic             uart_start;
    logic             uart_ready;
    logic [1:0]       grant_id;
    logic             busy;
    logic             hold_expired;

    int checks = 0;
    int errors = 0;
    int he_cnt = 0;
    int gap[NUM];
    int grants[$];
    logic [8:0] src_q[NUM][$];
    logic [8:0] exp_q[NUM][$];

    uart_tx_arbiter #(
        .NUM_REQ      (NUM),
        .HOLD_TIMEOUT (HT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .uart_data    (uart_data),
        .uart_start   (uart_start),
        .uart_ready   (uart_ready),
        .grant_id     (grant_id),
        .busy         (busy),
        .hold_expired (hold_expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_next(input int p, input logic [NUM-1:0] v);
        for (int k = 1; k <= NUM; k++)
            if (v[(p + k) % NUM]) return (p + k) % NUM;
        return -1;
    endfunction

    // transmitter: ready falls the cycle after a start and comes back 20 cycles later
    initial begin
        uart_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (uart_start === 1'b1) begin
                @(posedge clk);
                #1 uart_ready = 1'b0;
                repeat (20) @(posedge clk);
                #1 uart_ready = 1'b1;
            end
        end
    end

    // monitor: message-level model of who may send, when, and what the transmitter must see
    initial begin
        int ptr, locked, phase, idle, lane, want;
        logic seen_low, due, he_next, exp_any;
        logic [7:0] exp_byte;
        logic [8:0] item;
        logic [NUM-1:0] acc;
        ptr = NUM - 1; locked = -1; phase = 0; idle = 0;
        seen_low = 0; due = 0; he_next = 0; exp_byte = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ptr = NUM - 1; locked = -1; phase = 0; idle = 0;
                seen_low = 0; due = 0; he_next = 0;
            end else begin
                acc = req_valid & req_ready;
                if (hold_expired === 1'b1) he_cnt++;
                chk("hold_expired", hold_expired, he_next);
                he_next = 0;
                chk("busy", busy, (phase != 0) || (locked >= 0));
                chk("ready_onehot", ($countones(req_ready) <= 1) && ((req_ready & ~req_valid) == '0), 1);
                if (due) begin
                    chk("start_latency", uart_start, 1);
                    chk("uart_data", uart_data, exp_byte);
                    due = 0;
                end else begin
                    chk("no_extra_start", uart_start, 0);
                end
                exp_any = (phase == 0) && ((locked >= 0) ? req_valid[locked] : (uart_ready && (req_valid != '0)));
                chk("accept", acc != '0, exp_any);
                if (acc != '0) begin
                    lane = 0;
                    for (int i = 0; i < NUM; i++) if (acc[i]) lane = i;
                    want = (locked >= 0) ? locked : rr_next(ptr, req_valid);
                    chk("grant_lane", lane, want);
                    grants.push_back(lane);
                    chk("exp_available", exp_q[lane].size() > 0, 1);
                    item = (exp_q[lane].size() > 0) ? exp_q[lane].pop_front() : 9'h000;
                    exp_byte = item[7:0];
                    due = 1;
                    ptr = lane;
                    locked = item[8] ? -1 : lane;
                    phase = 1; seen_low = 0; idle = 0;
                end else if (phase == 0 && locked >= 0) begin
                    idle++;
                    if (idle == HT) begin
                        he_next = 1;
                        locked = -1;
                    end
                end
                if (phase == 1) begin
                    if (!uart_ready) seen_low = 1;
                    else if (seen_low) phase = 0;
                end
            end
        end
    end

    task automatic load(input int l, input logic [7:0] b, input logic last);
        src_q[l].push_back({last, b});
    endtask

    // one cycle of lane drivers: drop accepted bytes, present queued ones after their gap
    task automatic step();
        logic [NUM-1:0] acc;
        logic [8:0] item;
        @(negedge clk);
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM; i++) begin
            if (acc[i]) begin
                req_valid[i] = 1'b0;
                gap[i] = $urandom_range(0, 3);
            end
            if (!req_valid[i]) begin
                req_data[8*i +: 8] = 8'($urandom);
                req_last[i] = 1'($urandom);
                if (!acc[i] && src_q[i].size() > 0) begin
                    if (gap[i] > 0) gap[i]--;
                    else begin
                        item = src_q[i].pop_front();
                        req_data[8*i +: 8] = item[7:0];
                        req_last[i] = item[8];
                        req_valid[i] = 1'b1;
                        exp_q[i].push_back(item);
                    end
                end
            end
        end
    endtask

    function automatic logic all_idle();
        logic r;
        r = !busy && uart_ready && (req_valid == '0);
        for (int i = 0; i < NUM; i++)
            if (src_q[i].size() != 0 || exp_q[i].size() != 0) r = 0;
        return r;
    endfunction

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (n <= budget && !all_idle()) begin
            step();
            n++;
        end
        chk("drain_in_budget", n <= budget, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_uart_start"}, uart_start, 0);
        chk({tag, "_uart_data"}, uart_data, 0);
        chk({tag, "_grant_id"}, grant_id, NUM - 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_hold_expired"}, hold_expired, 0);
        chk({tag, "_req_ready"}, req_ready, 0);
    endtask

    initial begin
        int base, n, len, l;
        int rr_exp[5];
        int lock_exp[4];
        rr_exp = '{0, 1, 2, 3, 0};
        lock_exp = '{1, 1, 1, 3};
        rst_n = 1'b0;
        req_valid = '0;
        req_last = '0;
        req_data = '0;
        for (int i = 0; i < NUM; i++) gap[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        for (int i = 0; i < NUM; i++) load(i, 8'hA0 + 8'(i), 1'b1);
        load(0, 8'hB0, 1'b1);
        drain(2000);
        chk("rr_count", grants.size(), 5);
        for (int k = 0; k < 5 && k < grants.size(); k++) chk($sformatf("rr_order_%0d", k), grants[k], rr_exp[k]);

        base = grants.size();
        load(2, 8'h41, 1'b1);
        drain(200);
        chk("single_count", grants.size() - base, 1);
        for (int k = base; k < grants.size() && k < base + 1; k++) chk("single_lane", grants[k], 2);
        chk("single_grant_id", grant_id, 2);
        chk("single_busy_after", busy, 0);

        base = grants.size();
        load(1, 8'h10, 1'b0);
        load(1, 8'h11, 1'b0);
        load(1, 8'h12, 1'b1);
        load(3, 8'h33, 1'b1);
        gap[1] = 0;
        gap[3] = 2;
        drain(500);
        chk("lock_count", grants.size() - base, 4);
        for (int k = 0; k < 4 && base + k < grants.size(); k++) chk($sformatf("lock_order_%0d", k), grants[base + k], lock_exp[k]);

        for (int m = 0; m < 40; m++) begin
            l = $urandom_range(0, NUM - 1);
            len = $urandom_range(1, 3);
            for (int b = 0; b < len; b++) load(l, 8'($urandom), b == len - 1);
        end
        for (int i = 0; i < NUM; i++) gap[i] = $urandom_range(0, 5);
        drain(8000);

        base = grants.size();
        n = he_cnt;
        load(0, 8'h55, 1'b0);
        load(1, 8'h77, 1'b1);
        gap[0] = 0;
        gap[1] = 3;
        drain(400);
        chk("timeout_pulses", he_cnt - n, 1);
        chk("timeout_count", grants.size() - base, 2);
        for (int k = base + 1; k < grants.size() && k < base + 2; k++) chk("timeout_next_lane", grants[k], 1);

        load(2, 8'h99, 1'b1);
        gap[2] = 0;
        n = 0;
        while (!(busy && !uart_ready) && n < 100) begin
            step();
            n++;
        end
        chk("reach_wait_done", busy && !uart_ready, 1);
        repeat (3) step();
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        for (int i = 0; i < NUM; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
            gap[i] = 0;
        end
        req_valid = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        base = grants.size();
        load(2, 8'hC2, 1'b1);
        load(0, 8'hC0, 1'b1);
        drain(400);
        chk("post_reset_count", grants.size() - base, 2);
        for (int k = base; k < grants.size() && k < base + 1; k++) chk("post_reset_first", grants[k], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
